// File: rtl/hsid_pkg.sv
// Shared types and default widths for the HSID capture path.
//
// Contents:
//   HSID_WORD_WIDTH          packed output word width (even)
//   HSID_HSP_BANDS_WIDTH     width of the per-vector band count
//   HSID_BAND_WIDTH          width of one band sample (half a word)
//   hsid_band_packer_state_t state encoding of the band packer
package hsid_pkg;

    localparam int HSID_WORD_WIDTH      = 16;
    localparam int HSID_HSP_BANDS_WIDTH = 8;
    localparam int HSID_BAND_WIDTH      = HSID_WORD_WIDTH / 2;

    typedef enum logic [2:0] {
        HB_IDLE  = 3'd0,
        HB_LOW   = 3'd1,
        HB_HIGH  = 3'd2,
        HB_FLUSH = 3'd3,
        HB_DONE  = 3'd4,
        HB_ERROR = 3'd5,
        HB_CLEAR = 3'd6
    } hsid_band_packer_state_t;

endpackage

// File: rtl/hsid_band_packer_sva.sv
// Protocol checker for hsid_band_packer, bound onto every instance.
//
// Ports (all inputs, observed from the packer):
//   clk, rst_n, clear            clock, async reset, abort request
//   idle, band_ready             packer status / band-side handshake
//   pack_valid, pack_ready       pack-side handshake
//   pack_data, pack_last         pack payload
//   done, error, cancelled       completion status pulses
module hsid_band_packer_sva
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH = HSID_WORD_WIDTH
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  clear,
    input logic                  idle,
    input logic                  band_ready,
    input logic                  pack_valid,
    input logic                  pack_ready,
    input logic [WORD_WIDTH-1:0] pack_data,
    input logic                  pack_last,
    input logic                  done,
    input logic                  error,
    input logic                  cancelled
);

    // A pending pack must not change until it is taken (or aborted).
    a_pack_hold: assert property (@(posedge clk) disable iff (!rst_n)
        pack_valid && !pack_ready && !clear
        |=> pack_valid && $stable(pack_data) && $stable(pack_last));

    a_status_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({done, error, cancelled}));

    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);

    a_error_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        error |=> !error);

    a_cancel_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        cancelled |=> !cancelled);

    a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        idle |-> !band_ready && !pack_valid);

    a_last_has_valid: assert property (@(posedge clk) disable iff (!rst_n)
        pack_last |-> pack_valid);

    a_cancel_drops_pack: assert property (@(posedge clk) disable iff (!rst_n)
        cancelled |-> !pack_valid);

endmodule

bind hsid_band_packer hsid_band_packer_sva #(
    .WORD_WIDTH (WORD_WIDTH)
) u_hsid_band_packer_sva (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .idle       (idle),
    .band_ready (band_ready),
    .pack_valid (pack_valid),
    .pack_ready (pack_ready),
    .pack_data  (pack_data),
    .pack_last  (pack_last),
    .done       (done),
    .error      (error),
    .cancelled  (cancelled)
);

// File: rtl/hsid_band_packer.sv
// Packs a vector of HSP band samples, two per output word, for the
// captured-vector FIFO. Even bands fill the low half, odd bands the high
// half; an odd-length vector ends with a zero high half.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   clear                       synchronous abort of the current vector
//   start, hsp_bands            begin a vector of hsp_bands bands (idle only)
//   band_valid/ready, band_data band input stream (WORD_WIDTH/2 bits)
//   pack_valid/ready, pack_data packed output stream (WORD_WIDTH bits)
//   pack_last                   final pack of the vector
//   idle, done, error, cancelled status (done/error/cancelled are pulses)
//
// state    | meaning
// ---------+---------------------------------------------------------
// HB_IDLE  | waiting for start
// HB_LOW   | waiting for an even band (low half of the next pack)
// HB_HIGH  | waiting for an odd band (high half), then emit the pack
// HB_FLUSH | all bands taken, waiting for the last pack to drain
// HB_DONE  | done pulse, reinitialise, back to idle
// HB_ERROR | zero-length vector requested; error pulse, back to idle
// HB_CLEAR | vector aborted; cancelled pulse, back to idle
module hsid_band_packer
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH      = HSID_WORD_WIDTH,
    parameter int HSP_BANDS_WIDTH = HSID_HSP_BANDS_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       start,
    input  logic [HSP_BANDS_WIDTH-1:0] hsp_bands,
    input  logic                       band_valid,
    input  logic [WORD_WIDTH/2-1:0]    band_data,
    output logic                       band_ready,
    output logic                       pack_valid,
    output logic [WORD_WIDTH-1:0]      pack_data,
    output logic                       pack_last,
    input  logic                       pack_ready,
    output logic                       idle,
    output logic                       done,
    output logic                       error,
    output logic                       cancelled
);

    localparam int HALF = WORD_WIDTH / 2;

    hsid_band_packer_state_t state_q, state_d;

    logic [HSP_BANDS_WIDTH-1:0] cfg_hsp_bands_q, cfg_hsp_bands_d;
    logic [HSP_BANDS_WIDTH-1:0] band_count_q, band_count_d;
    logic [WORD_WIDTH-1:0]      pack_data_q, pack_data_d;
    logic                       pack_valid_q, pack_valid_d;
    logic                       pack_last_q, pack_last_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;
    logic                       cancelled_q, cancelled_d;

    logic                       collecting;
    logic                       band_fire;
    logic                       pack_fire;
    logic                       abort;
    logic [HSP_BANDS_WIDTH:0]   count_inc;
    logic                       last_band;

    // One extra bit so an all-ones band count compares without wrapping.
    assign count_inc = {1'b0, band_count_q} + {{HSP_BANDS_WIDTH{1'b0}}, 1'b1};
    assign last_band = (count_inc == {1'b0, cfg_hsp_bands_q});

    assign collecting = (state_q == HB_LOW) || (state_q == HB_HIGH);
    assign abort      = clear && (state_q != HB_IDLE) && (state_q != HB_CLEAR);

    // Gating with clear keeps an aborted cycle from also consuming a band.
    assign band_ready = collecting && !clear && (!pack_valid_q || pack_ready);
    assign band_fire  = band_valid && band_ready;
    assign pack_fire  = pack_valid_q && pack_ready;

    always_comb begin
        state_d         = state_q;
        cfg_hsp_bands_d = cfg_hsp_bands_q;
        band_count_d    = band_count_q;
        pack_data_d     = pack_data_q;
        pack_valid_d    = pack_valid_q;
        pack_last_d     = pack_last_q;
        done_d          = 1'b0;
        error_d         = 1'b0;
        cancelled_d     = 1'b0;

        if (pack_fire) begin
            pack_valid_d = 1'b0;
            pack_last_d  = 1'b0;
        end

        case (state_q)
            HB_IDLE: begin
                if (start) begin
                    if (hsp_bands == '0) begin
                        state_d = HB_ERROR;
                        error_d = 1'b1;
                    end else begin
                        cfg_hsp_bands_d = hsp_bands;
                        band_count_d    = '0;
                        state_d         = HB_LOW;
                    end
                end
            end
            HB_LOW: begin
                if (band_fire) begin
                    // Zeroing the high half here covers the odd-length tail.
                    pack_data_d  = {{HALF{1'b0}}, band_data};
                    band_count_d = count_inc[HSP_BANDS_WIDTH-1:0];
                    if (last_band) begin
                        pack_valid_d = 1'b1;
                        pack_last_d  = 1'b1;
                        state_d      = HB_FLUSH;
                    end else begin
                        state_d = HB_HIGH;
                    end
                end
            end
            HB_HIGH: begin
                if (band_fire) begin
                    // Overrides the pack_fire clear above: back-to-back packs.
                    pack_data_d  = {band_data, pack_data_q[HALF-1:0]};
                    pack_valid_d = 1'b1;
                    pack_last_d  = last_band;
                    band_count_d = count_inc[HSP_BANDS_WIDTH-1:0];
                    state_d      = last_band ? HB_FLUSH : HB_LOW;
                end
            end
            HB_FLUSH: begin
                if (pack_fire) begin
                    state_d = HB_DONE;
                    done_d  = 1'b1;
                end
            end
            HB_DONE, HB_ERROR, HB_CLEAR: begin
                cfg_hsp_bands_d = '1;
                band_count_d    = '0;
                pack_valid_d    = 1'b0;
                pack_last_d     = 1'b0;
                state_d         = HB_IDLE;
            end
            default: begin
                state_d = HB_IDLE;
            end
        endcase

        if (abort) begin
            state_d      = HB_CLEAR;
            cancelled_d  = 1'b1;
            done_d       = 1'b0;
            error_d      = 1'b0;
            pack_valid_d = 1'b0;
            pack_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= HB_IDLE;
            cfg_hsp_bands_q <= '1;
            band_count_q    <= '0;
            pack_data_q     <= '0;
            pack_valid_q    <= 1'b0;
            pack_last_q     <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            cancelled_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cfg_hsp_bands_q <= cfg_hsp_bands_d;
            band_count_q    <= band_count_d;
            pack_data_q     <= pack_data_d;
            pack_valid_q    <= pack_valid_d;
            pack_last_q     <= pack_last_d;
            done_q          <= done_d;
            error_q         <= error_d;
            cancelled_q     <= cancelled_d;
        end
    end

    assign pack_valid = pack_valid_q;
    assign pack_data  = pack_data_q;
    assign pack_last  = pack_last_q;
    assign idle       = (state_q == HB_IDLE);
    assign done       = done_q;
    assign error      = error_q;
    assign cancelled  = cancelled_q;

endmodule

// File: tb/tb_hsid_band_packer.sv
// Randomized bench for hsid_band_packer: expected packs are built from the
// band list (pairs of bands, zero high half on an odd tail) and compared
// against every accepted pack, alongside directed error/clear/reset cases.
module tb_hsid_band_packer;
    import hsid_pkg::*;

    localparam int WW = HSID_WORD_WIDTH;
    localparam int BW = WW / 2;
    localparam int NW = HSID_HSP_BANDS_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          start;
    logic [NW-1:0] hsp_bands;
    logic          band_valid;
    logic [BW-1:0] band_data;
    logic          band_ready;
    logic          pack_valid;
    logic [WW-1:0] pack_data;
    logic          pack_last;
    logic          pack_ready;
    logic          idle;
    logic          done;
    logic          error;
    logic          cancelled;

    int n_checks = 0;
    int n_errors = 0;

    logic [BW-1:0] bands_q[$];

    always #5 clk = ~clk;

    hsid_band_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .start      (start),
        .hsp_bands  (hsp_bands),
        .band_valid (band_valid),
        .band_data  (band_data),
        .band_ready (band_ready),
        .pack_valid (pack_valid),
        .pack_data  (pack_data),
        .pack_last  (pack_last),
        .pack_ready (pack_ready),
        .idle       (idle),
        .done       (done),
        .error      (error),
        .cancelled  (cancelled)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic fill_random(input int n);
        bands_q.delete();
        for (int i = 0; i < n; i++) bands_q.push_back(BW'($urandom));
    endtask

    task automatic fill_list(input int n, input int first);
        bands_q.delete();
        for (int i = 0; i < n; i++) bands_q.push_back(BW'(first + i));
    endtask

    task automatic do_start(input int n);
        int nn;
        nn = n;
        @(negedge clk);
        #1;
        check_eq("idle_before_start", idle, 1);
        start     = 1'b1;
        hsp_bands = nn[NW-1:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed_bands(input int k);
        int idx = 0;
        int cyc = 0;
        while (idx < k && cyc < 100) begin
            band_valid = 1'b1;
            band_data  = bands_q[idx];
            pack_ready = 1'b1;
            #1;
            if (band_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        band_valid = 1'b0;
        check_eq("feed_bands", idx, k);
    endtask

    // mode 0: full rate; mode 1: random valid/ready; mode 2: 5-cycle stall on first pack
    task automatic run_vector(input int n, input int mode);
        logic [WW-1:0] exp_data[$];
        bit            exp_last[$];
        logic [BW-1:0] lo, hi;
        logic [WW-1:0] held_data;
        logic          held_last;
        int npk, idx, got, cycles, budget, stall_left, first_fire, last_fire;
        bit held, expect_done, finished, stall_armed;

        npk = (n + 1) / 2;
        for (int k = 0; k < npk; k++) begin
            lo = bands_q[2*k];
            hi = (2*k + 1 < n) ? bands_q[2*k+1] : '0;
            exp_data.push_back({hi, lo});
            exp_last.push_back(k == npk - 1);
        end

        idx = 0; got = 0; cycles = 0; budget = 20 * n + 50;
        stall_left = 0; stall_armed = 0; first_fire = -1; last_fire = -1;
        held = 0; held_data = '0; held_last = 0; expect_done = 0; finished = 0;

        do_start(n);
        while (!finished && cycles < budget) begin
            band_valid = (idx < n) && (mode != 1 || $urandom_range(0, 3) != 0);
            band_data  = (idx < n) ? bands_q[idx] : '0;
            case (mode)
                0: pack_ready = 1'b1;
                1: pack_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!stall_armed && pack_valid) begin
                        stall_armed = 1;
                        stall_left  = 5;
                    end
                    pack_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
            endcase
            #1;
            check_eq("done_timing", done, expect_done);
            if (expect_done) begin
                finished = 1;
            end else begin
                if (held) begin
                    check_eq("hold_valid", pack_valid, 1);
                    check_eq("hold_data", pack_data, held_data);
                    check_eq("hold_last", pack_last, held_last);
                end
                if (pack_valid && !pack_ready) begin
                    check_eq("stall_band_ready", band_ready, 0);
                    held      = 1;
                    held_data = pack_data;
                    held_last = pack_last;
                end else begin
                    held = 0;
                end
                if (pack_valid && pack_ready) begin
                    if (got < npk) begin
                        check_eq("pack_data", pack_data, exp_data[got]);
                        check_eq("pack_last", pack_last, exp_last[got]);
                    end else begin
                        check_eq("extra_pack", got, npk);
                    end
                    if (first_fire < 0) first_fire = cycles;
                    last_fire = cycles;
                    got++;
                    if (got == npk) expect_done = 1;
                end
                if (band_valid && band_ready) idx++;
                @(negedge clk);
                cycles++;
            end
        end
        band_valid = 1'b0;
        check_eq("vector_completes", finished, 1);
        check_eq("pack_count", got, npk);
        check_eq("bands_used", idx, n);
        if (mode == 0 && n % 2 == 0 && npk > 1)
            check_eq("full_rate_spacing", last_fire - first_fire, 2 * (npk - 1));
        @(negedge clk);
        #1;
        check_eq("idle_after_done", idle, 1);
        check_eq("done_one_cycle", done, 0);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; start = 1'b0; hsp_bands = '0;
        band_valid = 1'b0; band_data = '0; pack_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_idle", idle, 1);
        check_eq("rst_band_ready", band_ready, 0);
        check_eq("rst_pack_valid", pack_valid, 0);
        check_eq("rst_pack_data", pack_data, 0);
        check_eq("rst_pack_last", pack_last, 0);
        check_eq("rst_status", {done, error, cancelled}, 0);
        rst_n = 1'b1;

        // Four bands, full rate: {2,1} then {4,3}.
        fill_list(4, 1);
        run_vector(4, 0);

        // Three bands: {6,5} then {0,7}.
        fill_list(3, 5);
        run_vector(3, 0);

        // Downstream stall after the first pack.
        fill_list(4, 8'h21);
        run_vector(4, 2);

        // Zero-length vector.
        @(negedge clk);
        start = 1'b1; hsp_bands = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("err_pulse", error, 1);
        check_eq("err_no_pack", pack_valid, 0);
        check_eq("err_not_idle", idle, 0);
        @(negedge clk);
        #1;
        check_eq("err_one_cycle", error, 0);
        check_eq("err_back_idle", idle, 1);

        // Clear after 3 of 6 bands.
        fill_random(6);
        do_start(6);
        feed_bands(3);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check_eq("clr_cancelled", cancelled, 1);
        check_eq("clr_pack_valid", pack_valid, 0);
        check_eq("clr_not_idle", idle, 0);
        check_eq("clr_no_done", {done, error}, 0);
        @(negedge clk);
        #1;
        check_eq("clr_one_cycle", cancelled, 0);
        check_eq("clr_back_idle", idle, 1);

        // Reset mid-vector, then a fresh two-band vector.
        fill_random(6);
        do_start(6);
        feed_bands(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_idle", idle, 1);
        check_eq("mid_rst_band_ready", band_ready, 0);
        check_eq("mid_rst_pack_valid", pack_valid, 0);
        check_eq("mid_rst_pack_data", pack_data, 0);
        check_eq("mid_rst_pack_last", pack_last, 0);
        check_eq("mid_rst_status", {done, error, cancelled}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_eq("post_rst_quiet", {done, error, cancelled}, 0);
        end
        fill_random(2);
        run_vector(2, 1);

        // Randomized vectors.
        for (int v = 0; v < 20; v++) begin
            fill_random($urandom_range(1, 9));
            run_vector(bands_q.size(), 1);
        end

        fill_random(8);
        run_vector(8, 0);

        // All-ones band count must run to completion without wrapping.
        fill_random((1 << NW) - 1);
        run_vector((1 << NW) - 1, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
